// File: rtl/custom_types_pkg.sv
// Shared front-end types: machine word, fetch sequencer states and the HALT opcode.
package custom_types_pkg;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  opcode_t;

  typedef enum logic [1:0] {
    FETCH      = 2'd0,
    REDIR_WAIT = 2'd1,
    HALTED     = 2'd2
  } fetch_state_t;

  localparam opcode_t HALT = 6'b111111;
endpackage

// File: rtl/fd_latch.sv
// IF/ID pipeline register: load on enable, synchronous flush clears only the valid bit.
module fd_latch
  import custom_types_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  en,
  input  logic  flush,
  input  word_t instr_d,
  input  word_t pc_d,
  input  word_t npc_d,
  output word_t instr_q,
  output word_t pc_q,
  output word_t npc_q,
  output logic  valid_q
);

  // IF -> ID boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_q <= '0;
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (en) begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      valid_q <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// PC register, fetch sequencer and IF/ID latch for the 5-stage pipeline.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module fetch_unit
  import custom_types_pkg::*;
#(
  parameter word_t   PC_RESET    = 32'h0000_0000,
  parameter opcode_t HALT_OPCODE = HALT
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [3:0]  freeze,
  input  logic [3:0]  flush,
  input  logic        redirect_en,
  input  logic [31:0] redirect_pc,
  input  logic        mem_stall,
  input  logic        ihit,
  input  logic [31:0] imemload,
  output logic        imemREN,
  output logic [31:0] imemaddr,
  output logic [31:0] instr_fd,
  output logic [31:0] pc_fd,
  output logic [31:0] npc_fd,
  output logic        valid_fd,
  output logic        halted,
  output logic [31:0] fetch_count,
  output logic [31:0] stall_count
);

  fetch_state_t state;
  word_t        pc;
  word_t        saved_target;
  word_t        target;
  word_t        pc_plus4;
  logic         accept;
  logic         redir;
  logic         is_halt;
  logic         ld_fd;
  logic         fl_fd;
  logic         unused_bits;

  assign unused_bits = ^{freeze[2:0], flush[2:0], redirect_pc[1:0]};

  assign accept   = ihit & ~mem_stall & ~freeze[3];
  assign redir    = (flush[3] | redirect_en) & ~mem_stall;
  // A bare flush re-fetches from the current pc.
  assign target   = redirect_en ? {redirect_pc[31:2], 2'b00} : pc;
  assign pc_plus4 = pc + 32'd4;
  assign is_halt  = (imemload[31:26] == HALT_OPCODE);

  assign ld_fd = (state == FETCH) & accept & ~redir;
  assign fl_fd = ~mem_stall & (redir | (state == REDIR_WAIT));

  assign imemaddr = pc;
  assign imemREN  = (state != HALTED);
  assign halted   = (state == HALTED);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state        <= FETCH;
      pc           <= PC_RESET;
      saved_target <= '0;
    end else if (!mem_stall) begin
      case (state)
        FETCH: begin
          if (redir) begin
            if (ihit) begin
              pc <= target;
            end else begin
              saved_target <= target;
              state        <= REDIR_WAIT;
            end
          end else if (accept) begin
            if (is_halt) state <= HALTED;
            else         pc    <= pc_plus4;
          end
        end
        REDIR_WAIT: begin
          // The wrong-path miss completes before the address may move.
          if (ihit) begin
            pc    <= redir ? target : saved_target;
            state <= FETCH;
          end else if (redir) begin
            saved_target <= target;
          end
        end
        HALTED: begin
          if (redir) begin
            pc    <= target;
            state <= FETCH;
          end
        end
        default: state <= FETCH;
      endcase
    end
  end

  fd_latch u_fd_latch (
    .clk     (CLK),
    .rst_n   (nRST),
    .en      (ld_fd),
    .flush   (fl_fd),
    .instr_d (imemload),
    .pc_d    (pc),
    .npc_d   (pc_plus4),
    .instr_q (instr_fd),
    .pc_q    (pc_fd),
    .npc_q   (npc_fd),
    .valid_q (valid_fd)
  );

`ifdef FETCH_PERF_CNT_EN
  word_t fetch_cnt;
  word_t stall_cnt;

  function automatic word_t sat_inc(input word_t v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (ld_fd)            fetch_cnt <= sat_inc(fetch_cnt);
      if (imemREN && !ihit) stall_cnt <= sat_inc(stall_cnt);
    end
  end

  assign fetch_count = fetch_cnt;
  assign stall_count = stall_cnt;
`else
  assign fetch_count = '0;
  assign stall_count = '0;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: per-cycle comparison against a behavioural model plus literal checkpoints.
module tb_fetch_unit;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [3:0]  freeze, flush;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        mem_stall, ihit;
  logic [31:0] imemload;
  logic        imemREN;
  logic [31:0] imemaddr, instr_fd, pc_fd, npc_fd;
  logic        valid_fd, halted;
  logic [31:0] fetch_count, stall_count;

  int tests = 0;
  int fails = 0;
  bit run   = 1'b0;

  localparam logic [31:0] ADDI = 32'h2008_0001;
  localparam logic [31:0] HLT  = 32'hFC00_0000;

  fetch_unit dut (
    .CLK(CLK), .nRST(nRST), .freeze(freeze), .flush(flush),
    .redirect_en(redirect_en), .redirect_pc(redirect_pc),
    .mem_stall(mem_stall), .ihit(ihit), .imemload(imemload),
    .imemREN(imemREN), .imemaddr(imemaddr), .instr_fd(instr_fd),
    .pc_fd(pc_fd), .npc_fd(npc_fd), .valid_fd(valid_fd), .halted(halted),
    .fetch_count(fetch_count), .stall_count(stall_count)
  );

  always #5 CLK = ~CLK;

  // Behavioural model: mode 0 = fetching, 1 = waiting out a wrong-path miss, 2 = halted.
  int          m_mode;
  logic [31:0] m_pc, m_saved, m_instr, m_pcf, m_npc;
  logic        m_v;

  always @(posedge CLK or negedge nRST) begin
    logic        go, rd;
    logic [31:0] tgt;
    if (!nRST) begin
      m_mode = 0; m_pc = 32'h0; m_saved = 32'h0;
      m_instr = 32'h0; m_pcf = 32'h0; m_npc = 32'h0; m_v = 1'b0;
    end else if (!mem_stall) begin
      rd  = flush[3] | redirect_en;
      tgt = redirect_en ? (redirect_pc & 32'hFFFF_FFFC) : m_pc;
      go  = 1'b0;
      if (m_mode == 2) begin
        if (rd) begin m_pc = tgt; m_v = 1'b0; m_mode = 0; end
      end else if (m_mode == 1) begin
        m_v = 1'b0;
        if (rd) m_saved = tgt;
        if (ihit) begin m_pc = m_saved; m_mode = 0; end
      end else if (rd) begin
        m_v = 1'b0;
        if (ihit) m_pc = tgt;
        else begin m_saved = tgt; m_mode = 1; end
      end else if (!freeze[3] && ihit) begin
        m_instr = imemload; m_pcf = m_pc; m_npc = m_pc + 32'd4; m_v = 1'b1;
        if (imemload[31:26] == 6'h3F) m_mode = 2;
        else m_pc = m_pc + 32'd4;
      end
    end
  end

  always @(negedge CLK) begin
    if (run) begin
      tests++;
      if (imemaddr !== m_pc || imemREN !== (m_mode != 2) || halted !== (m_mode == 2) ||
          valid_fd !== m_v || (m_v && (instr_fd !== m_instr || pc_fd !== m_pcf || npc_fd !== m_npc))) begin
        fails++;
        $display("FAIL model t=%0t addr=%h ren=%b hlt=%b v=%b ins=%h pc=%h npc=%h | want addr=%h ren=%b hlt=%b v=%b ins=%h pc=%h npc=%h",
                 $time, imemaddr, imemREN, halted, valid_fd, instr_fd, pc_fd, npc_fd,
                 m_pc, m_mode != 2, m_mode == 2, m_v, m_instr, m_pcf, m_npc);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  task automatic step(input logic [3:0] fz, input logic [3:0] fl, input logic re,
                      input logic [31:0] rp, input logic ms, input logic ih, input logic [31:0] ld);
    freeze = fz; flush = fl; redirect_en = re; redirect_pc = rp;
    mem_stall = ms; ihit = ih; imemload = ld;
    @(negedge CLK); #1;
  endtask

  initial begin
    nRST = 1'b0;
    freeze = 4'h0; flush = 4'h0; redirect_en = 1'b0; redirect_pc = 32'h0;
    mem_stall = 1'b0; ihit = 1'b1; imemload = ADDI;
    repeat (2) @(negedge CLK);
    run = 1'b1;
    #1 nRST = 1'b1;
    chk("rst_addr", imemaddr, 32'h0);
    chk("rst_ren", {31'h0, imemREN}, 32'h1);
    chk("rst_valid", {31'h0, valid_fd}, 32'h0);
    chk("rst_halted", {31'h0, halted}, 32'h0);
    chk("rst_instr", instr_fd, 32'h0);

    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("c1_addr", imemaddr, 32'h4);
    chk("c1_pcfd", pc_fd, 32'h0);
    chk("c1_valid", {31'h0, valid_fd}, 32'h1);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("c2_addr", imemaddr, 32'h8);
    chk("c2_pcfd", pc_fd, 32'h4);
    chk("c2_npcfd", npc_fd, 32'h8);

    step(4'h8, 4'h0, 0, 32'h0, 0, 1, ADDI);
    step(4'h8, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("frz_addr", imemaddr, 32'h8);
    chk("frz_pcfd", pc_fd, 32'h4);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("unfrz_pcfd", pc_fd, 32'h8);
    chk("unfrz_addr", imemaddr, 32'hC);

    step(4'h0, 4'h0, 1, 32'h40, 0, 0, ADDI);
    chk("rw_addr", imemaddr, 32'hC);
    chk("rw_valid", {31'h0, valid_fd}, 32'h0);
    step(4'h0, 4'h0, 0, 32'h0, 0, 0, ADDI);
    chk("rw_addr2", imemaddr, 32'hC);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("rw_done_addr", imemaddr, 32'h40);
    chk("rw_done_valid", {31'h0, valid_fd}, 32'h0);

    step(4'h8, 4'h8, 1, 32'h100, 0, 1, ADDI);
    chk("flfz_addr", imemaddr, 32'h100);
    chk("flfz_valid", {31'h0, valid_fd}, 32'h0);

    step(4'h0, 4'h0, 1, 32'h20, 0, 1, ADDI);
    chk("to20_addr", imemaddr, 32'h20);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, HLT);
    chk("hlt_halted", {31'h0, halted}, 32'h1);
    chk("hlt_ren", {31'h0, imemREN}, 32'h0);
    chk("hlt_pcfd", pc_fd, 32'h20);
    chk("hlt_addr", imemaddr, 32'h20);
    step(4'h0, 4'h0, 0, 32'h0, 0, 0, ADDI);
    chk("hlt_hold", {31'h0, halted}, 32'h1);
    step(4'h0, 4'h0, 1, 32'h24, 0, 0, ADDI);
    chk("unhlt_ren", {31'h0, imemREN}, 32'h1);
    chk("unhlt_addr", imemaddr, 32'h24);
    chk("unhlt_valid", {31'h0, valid_fd}, 32'h0);

    step(4'h0, 4'h0, 1, 32'h10, 0, 1, ADDI);
    step(4'h0, 4'h0, 0, 32'h0, 1, 1, 32'h1111_2222);
    chk("ms_addr", imemaddr, 32'h10);
    chk("ms_valid", {31'h0, valid_fd}, 32'h0);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, 32'h1111_2222);
    chk("ms_pcfd", pc_fd, 32'h10);
    chk("ms_instr", instr_fd, 32'h1111_2222);
    chk("ms_addr2", imemaddr, 32'h14);

    step(4'h0, 4'h8, 0, 32'h0, 0, 1, ADDI);
    chk("refetch_addr", imemaddr, 32'h14);
    chk("refetch_valid", {31'h0, valid_fd}, 32'h0);

    step(4'h0, 4'h0, 1, 32'h203, 0, 1, ADDI);
    chk("align_addr", imemaddr, 32'h200);

    step(4'h0, 4'h0, 1, 32'hFFFF_FFFC, 0, 1, ADDI);
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("wrap_npc", npc_fd, 32'h0);
    chk("wrap_addr", imemaddr, 32'h0);

    step(4'h0, 4'h0, 1, 32'h80, 0, 0, ADDI);
    nRST = 1'b0;
    #1;
    chk("midrst_addr", imemaddr, 32'h0);
    chk("midrst_valid", {31'h0, valid_fd}, 32'h0);
    @(negedge CLK); #1;
    nRST = 1'b1;
    step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);
    chk("postrst_pcfd", pc_fd, 32'h0);
    chk("postrst_addr", imemaddr, 32'h4);
    repeat (3) step(4'h0, 4'h0, 0, 32'h0, 0, 1, ADDI);

    run = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
